// File: rtl/sysid_uptime_slave_if.sv
// Avalon-MM slave bus bundle for the system-ID / uptime block.
// The clock and reset stay as plain ports on the modules.
interface sysid_uptime_slave_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_uptime_slave.sv
// System ID / build info / 64-bit uptime slave with a fixed-latency read pipeline.
// Reading UPTIME_LO snapshots the upper half so a LO-then-HI read pair is coherent.
module sysid_uptime_slave #(
    parameter logic [31:0] SYS_ID        = 32'h0000_0001,
    parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
    parameter logic [15:0] HW_VERSION    = 16'h0002,
    parameter int          READ_LATENCY  = 1,
    parameter int          TICK_DIV      = 50,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    sysid_uptime_slave_if.slave  bus
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    localparam logic [2:0] A_SYS_ID  = 3'd0;
    localparam logic [2:0] A_TSTAMP  = 3'd1;
    localparam logic [2:0] A_INFO    = 3'd2;
    localparam logic [2:0] A_UP_LO   = 3'd3;
    localparam logic [2:0] A_UP_HI   = 3'd4;
    localparam logic [2:0] A_SCRATCH = 3'd5;
    localparam logic [2:0] A_CTRL    = 3'd6;

    logic [15:0] presc;
    logic [63:0] uptime;
    logic [31:0] hi_shadow;
    logic [31:0] scratch;
    logic        freeze;

    logic        ctrl_wr;
    logic        clr;
    logic [31:0] rd_mux;

    logic [READ_LATENCY:1]       vld_pipe;
    logic [READ_LATENCY:1][31:0] dat_pipe;

    assign ctrl_wr = bus.write && (bus.address == A_CTRL) && bus.byteenable[0];
    assign clr     = ctrl_wr && bus.writedata[1];

    // CLEAR wins over a coincident tick; FREEZE holds both counters in place.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc  <= '0;
            uptime <= '0;
        end else if (clr) begin
            presc  <= '0;
            uptime <= '0;
        end else if (!freeze) begin
            if (presc == TICK_LAST) begin
                presc  <= '0;
                uptime <= uptime + 64'd1;
            end else begin
                presc  <= presc + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            freeze <= 1'b0;
        end else if (ctrl_wr) begin
            freeze <= bus.writedata[0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= SCRATCH_RESET;
        end else if (bus.write && (bus.address == A_SCRATCH)) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) scratch[b*8 +: 8] <= bus.writedata[b*8 +: 8];
            end
        end
    end

    // Upper half captured from the same sample that feeds the LO read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_shadow <= '0;
        end else if (bus.read && (bus.address == A_UP_LO)) begin
            hi_shadow <= uptime[63:32];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            A_SYS_ID:  rd_mux = SYS_ID;
            A_TSTAMP:  rd_mux = TIMESTAMP;
            A_INFO:    rd_mux = {HW_VERSION, 8'h00, 8'(READ_LATENCY)};
            A_UP_LO:   rd_mux = uptime[31:0];
            A_UP_HI:   rd_mux = hi_shadow;
            A_SCRATCH: rd_mux = scratch;
            A_CTRL:    rd_mux = {31'd0, freeze};
            default:   rd_mux = '0;
        endcase
    end

    // Data rides zeroed when not valid, so readdata is 0 outside the strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= bus.read;
            dat_pipe[1] <= bus.read ? rd_mux : 32'd0;
            for (int i = 2; i <= READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign bus.readdatavalid = vld_pipe[READ_LATENCY];
    assign bus.readdata      = dat_pipe[READ_LATENCY];

endmodule

// File: doc/sysid_uptime_slave.md
Name: sysid_uptime_slave

Overview:
- Parametrised successor to the single-word system-ID slave: an Avalon-MM slave exposing system ID, build timestamp, a version/info word, a 64-bit free-running uptime counter with coherent split reads, a scratch register and a control register.
- Read path is pipelined with a configurable fixed latency and a readdatavalid strobe.
- Sits on the Nios II data master bus; software uses it to confirm the hardware/software pairing and to obtain a monotonic time base.

Parameters:
- SYS_ID, 32'h0000_0001, value returned at word 0.
- TIMESTAMP, 32'h0000_0000, build time (epoch seconds) returned at word 1.
- HW_VERSION, 16'h0002, returned in INFO[31:16].
- READ_LATENCY, 1, read latency in clock cycles from accept to readdatavalid; legal range 1..3.
- TICK_DIV, 50, clock cycles per uptime tick; legal range 1..65535.
- SCRATCH_RESET, 32'h0000_0000, reset value of SCRATCH.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word address.
- read  in  1  read request; accepted every cycle, no waitrequest.
- write  in  1  write request; accepted every cycle.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes; ignored on reads.
- readdata  out  32  read data, valid only when readdatavalid=1, else 0.
- readdatavalid  out  1  single-cycle strobe, READ_LATENCY cycles after the accepting read cycle.

Behaviour:
- Register map:
  - 0 SYS_ID (RO)
  - 1 TIMESTAMP (RO)
  - 2 INFO (RO): [31:16] HW_VERSION, [15:8] 0, [7:0] READ_LATENCY
  - 3 UPTIME_LO (RO)
  - 4 UPTIME_HI (RO)
  - 5 SCRATCH (RW, byteenable-qualified)
  - 6 CTRL (RW): bit0 FREEZE (sticky), bit1 CLEAR (write-1 pulse, always reads 0), bits[31:2] read 0
  - 7 reserved: reads 0, writes ignored
- Writes to RO and reserved addresses have no effect. No error response.
- Reset, asynchronous:
  - prescaler, uptime[63:0], hi_shadow and FREEZE go to 0; SCRATCH goes to SCRATCH_RESET.
  - The read pipeline is flushed: readdatavalid=0, readdata=0.
  - A read in flight when reset asserts is discarded and never returns.
- Prescaler:
  - Counts 0..TICK_DIV-1 while FREEZE=0.
  - In the cycle it equals TICK_DIV-1 it returns to 0 and uptime increments by 1 (mod 2^64; all-ones wraps to 0).
  - TICK_DIV=1 increments uptime every cycle.
- FREEZE=1 holds both prescaler and uptime. On release, counting resumes from the held values.
- CLEAR:
  - A write to CTRL with writedata[1]=1 (byteenable[0]=1) zeroes prescaler and uptime on the next edge.
  - CLEAR has priority over a coincident increment.
  - FREEZE is updated by the same write.
- Coherent 64-bit read:
  - A read accepted at address 3 returns uptime[31:0] as sampled in the accept cycle and loads hi_shadow with uptime[63:32] from the same sample.
  - A read at address 4 returns hi_shadow, never live uptime.
  - hi_shadow changes only on a read at address 3 (or reset).
- Read pipeline:
  - Data is sampled in the accept cycle and passed through a READ_LATENCY-deep valid/data shift pipeline.
  - Back-to-back reads every cycle are supported, with one readdatavalid per read, in order.
- Read and write to the same register in the same cycle: the read returns the pre-write value; the write takes effect on that edge.
- SCRATCH byte lanes: byte i is updated only when byteenable[i]=1.

Test Plan:
- Reset, then read addresses 0, 1, 2 back-to-back with READ_LATENCY=2, HW_VERSION=16'h0002 -> three readdatavalid pulses on cycles accept+2, +3, +4 with SYS_ID, TIMESTAMP, 32'h0002_0002; readdata=0 otherwise.
- TICK_DIV=4, run 40 cycles after reset, read address 3 -> value 10 ±1 per the exact accept cycle; read address 4 -> 0.
- Force uptime to 32'hFFFF_FFFF via a backdoor, TICK_DIV=1, read address 3 on the carry cycle, then address 4 -> LO/HI form one consistent 64-bit value (either 0x0_FFFFFFFF or 0x1_00000000), never 0x1_FFFFFFFF or 0x0_00000000.
- Write SCRATCH 32'hA5A5_A5A5 with byteenable 4'b1111, then 32'h1234_5678 with byteenable 4'b0101 -> reads 32'hA534_A578; write to address 0 -> SYS_ID is unchanged.
- Write CTRL=1 (freeze), wait 100 cycles -> two UPTIME_LO reads are equal. Write CTRL=2 -> UPTIME_LO reads 0 and FREEZE=0, so counting resumes.
- Issue a read, assert reset_n=0 before readdatavalid, release reset -> no readdatavalid for that read; SCRATCH=SCRATCH_RESET; uptime restarts from 0.
